// File: rtl/alu_sequencer_pkg.sv
// Shared types and constants for the ALU command sequencer and its register file.
package alu_sequencer_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = 2;

    typedef enum logic [1:0] {
        CMD_LOAD = 2'd0,
        CMD_ADD  = 2'd1,
        CMD_SUB  = 2'd2,
        CMD_READ = 2'd3
    } cmd_code_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

endpackage

// File: rtl/reg_file4x8.sv
// Register file: one synchronous write port, two asynchronous read ports, async clear.
module reg_file4x8
    import alu_sequencer_pkg::*;
#(
    parameter int unsigned NREG = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [IDX_W-1:0]  raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o
);

    logic [DATA_W-1:0] regs_q [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = regs_q[raddr_a_i];
    assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/alu_sequencer.sv
// Command sequencer: LOAD/READ answer in one cycle, ADD/SUB drive an external
// adder/subtractor for two cycles before answering. One command in flight.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int unsigned NREG = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_code,
    input  logic [IDX_W-1:0]  cmd_rd,
    input  logic [IDX_W-1:0]  cmd_rs,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic              alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero
);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  rd_q, rd_d;
    logic              alu_op_q, alu_op_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              cmd_ready_q, cmd_ready_d;

    logic              rf_we;
    logic [IDX_W-1:0]  rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_rdata_a;
    logic [DATA_W-1:0] rf_rdata_b;

    // Read ports address straight from the command so operands are sampled
    // at accept time; this makes rd == rs see the pre-write value.
    reg_file4x8 #(
        .NREG (NREG)
    ) u_reg_file (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_i      (rf_we),
        .waddr_i   (rf_waddr),
        .wdata_i   (rf_wdata),
        .raddr_a_i (cmd_rd),
        .rdata_a_o (rf_rdata_a),
        .raddr_b_i (cmd_rs),
        .rdata_b_o (rf_rdata_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rd_q        <= '0;
            alu_op_q    <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        alu_op_d   = alu_op_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        rsp_data_d = rsp_data_q;
        rf_we      = 1'b0;
        rf_waddr   = rd_q;
        rf_wdata   = alu_result;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    rd_d = cmd_rd;
                    case (cmd_code_e'(cmd_code))
                        CMD_LOAD: begin
                            rf_we      = 1'b1;
                            rf_waddr   = cmd_rd;
                            rf_wdata   = cmd_imm;
                            rsp_data_d = cmd_imm;
                            state_d    = ST_RESP;
                        end
                        CMD_READ: begin
                            rsp_data_d = rf_rdata_b;
                            state_d    = ST_RESP;
                        end
                        CMD_ADD, CMD_SUB: begin
                            alu_op_d = (cmd_code_e'(cmd_code) == CMD_ADD);
                            alu_a_d  = rf_rdata_a;
                            alu_b_d  = rf_rdata_b;
                            state_d  = ST_ISSUE;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            ST_ISSUE: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                rf_we      = 1'b1;
                rf_waddr   = rd_q;
                rf_wdata   = alu_result;
                rsp_data_d = alu_result;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        rsp_valid_d = (state_d == ST_RESP);
        cmd_ready_d = (state_d == ST_IDLE);
    end

    assign cmd_ready = cmd_ready_q;
    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = (rsp_data_q == '0);

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: scoreboard of expected responses plus
// per-scenario latency, operand, backpressure and reset checks.
module tb_alu_sequencer;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_code;
    logic [1:0] cmd_rd;
    logic [1:0] cmd_rs;
    logic [7:0] cmd_imm;
    logic       alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_result;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_zero;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];
    logic [7:0] mon_exp;
    logic [7:0] model [4];

    alu_sequencer #(.NREG(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_code   (cmd_code),
        .cmd_rd     (cmd_rd),
        .cmd_rs     (cmd_rs),
        .cmd_imm    (cmd_imm),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_zero   (rsp_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External adder/subtractor
    assign alu_result = alu_op ? 8'(alu_a + alu_b) : 8'(alu_a - alu_b);

    // Response monitor: pop and compare on every handshake
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got data=%02h, required no response", rsp_data);
            end else begin
                mon_exp = sb.pop_front();
                if (rsp_data !== mon_exp || rsp_zero !== (mon_exp == 8'h00)) begin
                    errors++;
                    $display("FAIL rsp_data: got data=%02h zero=%b, required data=%02h zero=%b",
                             rsp_data, rsp_zero, mon_exp, (mon_exp == 8'h00));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "timeout");
    end

    task automatic send_cmd(input logic [1:0] code, input logic [1:0] rd, input logic [1:0] rs,
                            input logic [7:0] imm, input logic [7:0] exp_data,
                            input logic [7:0] exp_a, input logic [7:0] exp_b, input string name);
        int  n;
        int  lat;
        bit  got;
        bit  is_alu;
        is_alu = (code == 2'd1) || (code == 2'd2);
        lat    = is_alu ? 3 : 1;
        @(negedge clk);
        cmd_code  = code;
        cmd_rd    = rd;
        cmd_rs    = rs;
        cmd_imm   = imm;
        cmd_valid = 1'b1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s cmd_ready: got %b, required 1", name, cmd_ready);
        end
        sb.push_back(exp_data);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n   = 0;
        got = 1'b0;
        while (n < 10 && !got) begin
            @(negedge clk);
            n++;
            if (rsp_valid) got = 1'b1;
            if (is_alu && (n <= 2 || got)) begin
                checks++;
                if (alu_op !== (code == 2'd1) || alu_a !== exp_a || alu_b !== exp_b) begin
                    errors++;
                    $display("FAIL %s alu_cycle%0d: got op=%b a=%02h b=%02h, required op=%b a=%02h b=%02h",
                             name, n, alu_op, alu_a, alu_b, (code == 2'd1), exp_a, exp_b);
                end
            end
        end
        checks++;
        if (!got || n != lat) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles (seen=%b), required %0d", name, n, got, lat);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_code  = 2'd0;
        cmd_rd    = 2'd0;
        cmd_rs    = 2'd0;
        cmd_imm   = 8'h00;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 8'h00 || rsp_zero !== 1'b1 ||
            alu_op !== 1'b0 || alu_a !== 8'h00 || alu_b !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got vld=%b data=%02h zero=%b op=%b a=%02h b=%02h, required 0 00 1 0 00 00",
                     rsp_valid, rsp_data, rsp_zero, alu_op, alu_a, alu_b);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_cmd_ready: got %b, required 1", cmd_ready);
        end
    endtask

    task automatic test_add();
        send_cmd(2'd0, 2'd0, 2'd0, 8'h05, 8'h05, 8'h00, 8'h00, "add_load_r0");
        send_cmd(2'd0, 2'd1, 2'd0, 8'h03, 8'h03, 8'h00, 8'h00, "add_load_r1");
        send_cmd(2'd1, 2'd0, 2'd1, 8'h00, 8'h08, 8'h05, 8'h03, "add_r0_r1");
    endtask

    task automatic test_sub_read();
        send_cmd(2'd0, 2'd2, 2'd0, 8'h03, 8'h03, 8'h00, 8'h00, "sub_load_r2");
        send_cmd(2'd0, 2'd3, 2'd0, 8'h05, 8'h05, 8'h00, 8'h00, "sub_load_r3");
        send_cmd(2'd2, 2'd2, 2'd3, 8'h00, 8'hFE, 8'h03, 8'h05, "sub_r2_r3");
        send_cmd(2'd3, 2'd0, 2'd2, 8'h00, 8'hFE, 8'h00, 8'h00, "read_r2");
    endtask

    task automatic test_wrap();
        send_cmd(2'd0, 2'd0, 2'd0, 8'hFF, 8'hFF, 8'h00, 8'h00, "wrap_load_r0");
        send_cmd(2'd0, 2'd1, 2'd0, 8'h01, 8'h01, 8'h00, 8'h00, "wrap_load_r1");
        send_cmd(2'd1, 2'd0, 2'd1, 8'h00, 8'h00, 8'hFF, 8'h01, "wrap_add");
    endtask

    task automatic test_backpressure();
        send_cmd(2'd0, 2'd1, 2'd0, 8'h40, 8'h40, 8'h00, 8'h00, "bp_load_r1");
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        send_cmd(2'd1, 2'd1, 2'd1, 8'h00, 8'h80, 8'h40, 8'h40, "bp_add_r1_r1");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 8'h80 || cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall%0d: got vld=%b data=%02h rdy=%b, required 1 80 0",
                         i, rsp_valid, rsp_data, cmd_ready);
            end
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        send_cmd(2'd0, 2'd0, 2'd0, 8'h10, 8'h10, 8'h00, 8'h00, "rm_load_r0");
        @(negedge clk);
        cmd_code  = 2'd1;
        cmd_rd    = 2'd0;
        cmd_rs    = 2'd0;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 8'h00 || alu_op !== 1'b0 ||
            alu_a !== 8'h00 || alu_b !== 8'h00) begin
            errors++;
            $display("FAIL rm_async_clear: got vld=%b data=%02h op=%b a=%02h b=%02h, required 0 00 0 00 00",
                     rsp_valid, rsp_data, alu_op, alu_a, alu_b);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL rm_no_rsp%0d: got vld=%b rdy=%b, required 0 1", i, rsp_valid, cmd_ready);
            end
        end
        send_cmd(2'd3, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, "rm_read_r0");
    endtask

    task automatic test_back_to_back();
        logic [1:0] code, rd, rs;
        logic [7:0] imm, exp, a, b;
        for (int i = 0; i < 4; i++) model[i] = 8'h00;
        for (int i = 0; i < 30; i++) begin
            code = 2'($urandom_range(0, 3));
            rd   = 2'($urandom_range(0, 3));
            rs   = 2'($urandom_range(0, 3));
            imm  = 8'($urandom_range(0, 255));
            a    = model[rd];
            b    = model[rs];
            case (code)
                2'd0: exp = imm;
                2'd1: exp = 8'(a + b);
                2'd2: exp = 8'(a - b);
                default: exp = b;
            endcase
            if (code != 2'd3) model[rd] = exp;
            send_cmd(code, rd, rs, imm, exp, a, b, "b2b");
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_read();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending responses, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: NREG, 4, number of 8-bit registers in the internal register file (fixed at 4; index width 2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  sequencer can accept a command.
REQ-006 cmd_code  input  2  0=LOAD, 1=ADD, 2=SUB, 3=READ.
REQ-007 cmd_rd  input  2  destination register index.
REQ-008 cmd_rs  input  2  source register index (second operand for ADD/SUB, read index for READ).
REQ-009 cmd_imm  input  8  immediate for LOAD.
REQ-010 alu_op  output  1  to external adder/subtractor: 1=add, 0=subtract.
REQ-011 alu_a  output  8  first operand (reg[rd]).
REQ-012 alu_b  output  8  second operand (reg[rs]).
REQ-013 alu_result  input  8  combinational result from external adder/subtractor.
REQ-014 rsp_valid  output  1  response present.
REQ-015 rsp_ready  input  1  consumer accepts response.
REQ-016 rsp_data  output  8  value written (LOAD/ADD/SUB) or read (READ).
REQ-017 rsp_zero  output  1  rsp_data == 0.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, CAPTURE, RESP.
REQ-019 cmd_ready SHALL be 1 only in IDLE; command accepted on cycle where cmd_valid && cmd_ready.
REQ-020 On accept, cmd fields SHALL be latched; LOAD writes cmd_imm to reg[rd] and goes to RESP; READ latches reg[rs] into rsp_data and goes to RESP; ADD/SUB go to ISSUE.
REQ-021 In ISSUE, alu_op/alu_a/alu_b SHALL be registered and stable (alu_op=1 for ADD, 0 for SUB); next state CAPTURE.
REQ-022 In CAPTURE, alu_result SHALL be written to reg[rd] and into rsp_data; operands held stable; next state RESP.
REQ-023 In RESP, rsp_valid SHALL be 1; rsp_data/rsp_zero held stable until rsp_valid && rsp_ready, then IDLE.
REQ-024 Latency: ADD/SUB accepted in cycle N -> rsp_valid first high in cycle N+3; LOAD/READ -> N+1.
REQ-025 Arithmetic SHALL be modulo 256 (wrap, no carry/borrow output).
REQ-026 rd == rs SHALL be legal: both operands read the pre-write value of that register.
REQ-027 No new command SHALL be accepted before the current response handshake completes (one outstanding command).
REQ-028 rsp_zero SHALL be computed from the registered rsp_data.
REQ-029 alu_op/alu_a/alu_b SHALL hold last issued values outside ISSUE/CAPTURE.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, all registers 0x00, rsp_data 0x00, rsp_valid 0, alu_op 0, alu_a/alu_b 0x00; cmd_ready 1 after release.
REQ-031 Reset mid-command SHALL abort it with no register write and no response.

Structure
REQ-032 Shared package SHALL hold the cmd_code enumeration (LOAD/ADD/SUB/READ), FSM state type, and data width constant 8.
REQ-033 Register file SHALL be one sub-module reg_file4x8: one write port, two asynchronous read ports, async active-low clear.

Verification
REQ-034 LOAD r0=0x05, LOAD r1=0x03, ADD rd=0 rs=1 -> alu_op=1, alu_a=0x05, alu_b=0x03, rsp_data=0x08, rsp_valid at N+3.
REQ-035 LOAD r2=0x03, LOAD r3=0x05, SUB rd=2 rs=3 -> rsp_data=0xFE, rsp_zero=0; READ rs=2 -> 0xFE.
REQ-036 LOAD r0=0xFF, LOAD r1=0x01, ADD rd=0 rs=1 -> rsp_data=0x00, rsp_zero=1 (wrap).
REQ-037 LOAD r1=0x40, ADD rd=1 rs=1 -> rsp_data=0x80; rsp_ready held low 5 cycles -> rsp_valid and 0x80 stable, cmd_ready=0 throughout.
REQ-038 Assert rst_n low in CAPTURE of ADD on r0=0x10 -> rsp_valid never rises; READ rs=0 after reset -> 0x00.
